// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking mask is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int INT_D = (BIN_W + 2) / 3;
    localparam int SCR_W = 4 * INT_D;
    localparam int PAD_W = 4 * (INT_D + DIGITS);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [SCR_W-1:0]    scr_q, scr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    logic [SCR_W-1:0]    adj_s;
    logic [SCR_W-1:0]    res_s;
    logic [PAD_W-1:0]    res_pad_s;
    logic [4*DIGITS-1:0] bcd_s;
    logic                ovf_s;

    // Add-3 correction on every scratch digit, then the one-bit shift into the scratch.
    always_comb begin
        adj_s = {SCR_W{1'b0}};
        for (int k = 0; k < INT_D; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = scr_q[4*k +: 4];
            end
        end
        res_s     = {adj_s[SCR_W-2:0], shift_q[BIN_W-1]};
        // Zero-padding keeps the digit split valid even when DIGITS exceeds the scratch depth.
        res_pad_s = {{(4*DIGITS){1'b0}}, res_s};
        bcd_s     = res_pad_s[4*DIGITS-1:0];
        ovf_s     = |res_pad_s[PAD_W-1:4*DIGITS];
    end

    // Next-state and registered-output logic for the IDLE/CONV controller.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin_in;
                    scr_d   = {SCR_W{1'b0}};
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                scr_d   = res_s;
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    bcd_d   = bcd_s;
                    ovf_d   = ovf_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= {BIN_W{1'b0}};
            scr_q   <= {SCR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= {(4*DIGITS){1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_s;
    logic              zero_run_s;

    // Leading-zero mask from the top digit down; digit 0 is never blanked, overflow shows all digits.
    always_comb begin
        blank_s    = {DIGITS{1'b0}};
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (bcd_s[4*i +: 4] == 4'd0);
            blank_s[i] = zero_run_s & ~ovf_s;
        end
    end

    // Blank mask register, updated on the same edge as the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= {DIGITS{1'b0}};
        end else if (done_d) begin
            blank_q <= blank_s;
        end else begin
            blank_q <= blank_q;
        end
    end

    assign blank = blank_q;
`else
    assign blank = {DIGITS{1'b0}};
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed, table-driven bench for bin2bcd_seq (BIN_W=16, DIGITS=4), plus handshake corner sequences.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;
    logic [3:0]  blank;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blk;
    } vec_t;

    vec_t tbl [11];

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [3:0] b);
`ifdef BIN2BCD_BLANK_EN
        return b;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Drive start for one cycle; returns in the first cycle after the accepting edge.
    task automatic launch(input logic [15:0] v);
        start  = 1'b1;
        bin_in = v;
        step();
        start  = 1'b0;
    endtask

    // Latency counted in cycles from the start cycle; capped so a stuck DUT cannot hang.
    task automatic wait_done(output int lat, output int bcyc);
        lat  = 1;
        bcyc = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat, bc;
        launch(v.bin);
        wait_done(lat, bc);
        chk({nm, "_latency"}, lat, 32'd17);
        chk({nm, "_busy_cycles"}, bc, 32'd16);
        chk({nm, "_bcd"}, bcd_out, v.bcd);
        chk({nm, "_ovf"}, ovf, v.ovf);
        chk({nm, "_blank"}, blank, exp_blank(v.blk));
        step();
        chk({nm, "_done_single"}, done, 1'b0);
    endtask

    initial begin
        int lat, bc, dn_cnt, first_lat;
        logic [15:0] cap_bcd;
        vec_t v;

        n_cmp = 0;
        n_bad = 0;
        tbl[0]  = '{16'd999,   16'h0999, 1'b0, 4'b1000};
        tbl[1]  = '{16'd0,     16'h0000, 1'b0, 4'b1110};
        tbl[2]  = '{16'd65535, 16'h5535, 1'b1, 4'b0000};
        tbl[3]  = '{16'd9999,  16'h9999, 1'b0, 4'b0000};
        tbl[4]  = '{16'd10000, 16'h0000, 1'b1, 4'b0000};
        tbl[5]  = '{16'd42,    16'h0042, 1'b0, 4'b1100};
        tbl[6]  = '{16'd7,     16'h0007, 1'b0, 4'b1110};
        tbl[7]  = '{16'd100,   16'h0100, 1'b0, 4'b1000};
        tbl[8]  = '{16'd1000,  16'h1000, 1'b0, 4'b0000};
        tbl[9]  = '{16'd50000, 16'h0000, 1'b1, 4'b0000};
        tbl[10] = '{16'd1234,  16'h1234, 1'b0, 4'b0000};

        rst = 1'b1; start = 1'b0; bin_in = 16'd0;
        step(); step();
        chk("por_busy", busy, 1'b0);
        chk("por_done", done, 1'b0);
        chk("por_bcd", bcd_out, 16'h0000);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset held two cycles while idle clears the held result.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd_out, 16'h0000);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_blank", blank, 4'b0000);
        step();

        // Back-to-back: 0 then 65535 started in the done cycle.
        launch(16'd0);
        wait_done(lat, bc);
        chk("b2b_first_lat", lat, 32'd17);
        chk("b2b_first_bcd", bcd_out, 16'h0000);
        chk("b2b_first_blank", blank, exp_blank(4'b1110));
        launch(16'd65535);
        wait_done(lat, bc);
        chk("b2b_second_lat", lat, 32'd17);
        chk("b2b_second_bcd", bcd_out, 16'h5535);
        chk("b2b_second_ovf", ovf, 1'b1);
        chk("b2b_second_blank", blank, 4'b0000);
        step();

        // Start while busy is dropped.
        launch(16'd9999);
        lat = 1;
        for (int k = 0; k < 4; k++) begin step(); lat++; end
        start = 1'b1; bin_in = 16'd1234;
        step(); lat++;
        start = 1'b0;
        dn_cnt = 0; first_lat = 0; cap_bcd = 16'h0000;
        while (lat < 60) begin
            if (done) begin
                dn_cnt++;
                if (dn_cnt == 1) begin first_lat = lat; cap_bcd = bcd_out; end
            end
            step(); lat++;
        end
        chk("busy_start_dones", dn_cnt, 32'd1);
        chk("busy_start_lat", first_lat, 32'd17);
        chk("busy_start_bcd", cap_bcd, 16'h9999);
        chk("busy_start_held", bcd_out, 16'h9999);

        // Reset at cycle 8 of a conversion aborts it with no done.
        launch(16'd4321);
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_bcd", bcd_out, 16'h0000);
        chk("abort_ovf", ovf, 1'b0);
        dn_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done || busy) dn_cnt++;
            step();
        end
        chk("abort_no_done", dn_cnt, 32'd0);
        chk("abort_bcd_held", bcd_out, 16'h0000);
        v = '{16'd4321, 16'h4321, 1'b0, 4'b0000};
        run_vec(v, "after_abort");

        // Counter sweep, each conversion started in the previous done cycle.
        launch(16'd0);
        for (int n = 0; n < 1000; n++) begin
            wait_done(lat, bc);
            chk("sweep_lat", lat, 32'd17);
            chk("sweep_bcd", bcd_out, ref_bcd(n));
            chk("sweep_ovf", ovf, 1'b0);
            if (n < 999) launch(16'(n + 1));
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double-dabble), one bit per clock. It sits between the free-running count register and the 7-segment scan/display stage. It takes an unsigned binary count and produces packed BCD digits, one nibble per display position. A start/busy/done handshake lets the counter domain request a conversion whenever the count changes.

Parameters:
BIN_W, 16, width of the unsigned binary input.
DIGITS, 4, number of BCD digits presented on bcd_out; digit 0 is the least significant, in bits [3:0].

Ports:
clk  input  1  sole clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bin_in  input  BIN_W  unsigned value; captured on the accepted-start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when bcd_out/ovf update.
bcd_out  output  4*DIGITS  packed BCD result; holds until the next done.
ovf  output  1  bin_in exceeded 10^DIGITS-1; holds until the next done.
blank  output  DIGITS  leading-zero mask, one bit per digit (see Optional Feature).

Behaviour:
- Reset and clock: one clock domain; reset is synchronous and active-high.
- Reset values:
  - busy=0, done=0, bcd_out=0, ovf=0, blank=0.
  - state=IDLE; shift register and bit counter cleared.
- Internal scratch: INT_D=(BIN_W+2)/3 digits, using integer division. This guarantees no internal loss for any bin_in.
- States: IDLE, CONV.
- IDLE:
  - start=1 -> latch bin_in into the shift register, clear scratch digits, load bit counter = BIN_W, go to CONV, busy=1 next cycle.
  - start=0 -> remain in IDLE.
- CONV, each cycle:
  - Every scratch digit >=5 gets +3.
  - Then shift {scratch, shift_reg} left by 1 bit.
  - Decrement the bit counter.
- Last shift (counter 1->0), on the same edge:
  - bcd_out <= low DIGITS scratch digits post-shift.
  - ovf <= OR of all scratch digits above DIGITS-1.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge E0. busy is high for cycles E0+1..E0+BIN_W. done is high in exactly one cycle, E0+BIN_W+1, with bcd_out valid from that cycle. With defaults that is 16 busy cycles and done 17 cycles after start.
- Handshake rules:
  - start while busy=1 is ignored; it is neither queued nor captured.
  - bin_in changes during CONV have no effect.
  - start=1 in the done cycle is accepted, because state is already IDLE. Back-to-back conversions therefore have a throughput of BIN_W+1 cycles.
  - done is registered; it is never asserted combinationally from start.
- Overflow: bcd_out is bin_in mod 10^DIGITS (low digits, truncated) and ovf=1. No saturation.
- Reset mid-conversion: the next edge returns all state and outputs to reset values, including clearing bcd_out. No done pulse is produced for the aborted conversion.
- Held-start: start held high continuously triggers a new conversion every BIN_W+1 cycles.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined:
  - blank updates on the done edge together with bcd_out.
  - blank[i]=1 iff digit i and all digits above it (up to DIGITS-1) are 0, for i>=1.
  - blank[0] is always 0, so the value zero shows a single "0".
  - ovf forces blank=0.
- Undefined: blank is tied to all zeros and no blanking logic is synthesized.

Test Plan:
- Reset: assert rst 2 cycles mid-idle -> busy=0, done=0, bcd_out=16'h0000, ovf=0, blank=4'b0000.
- Convert 999: start=1 with bin_in=999 for one cycle -> busy high 16 cycles, done pulse exactly 17 cycles after start, bcd_out=16'h0999, ovf=0; with BIN2BCD_BLANK_EN, blank=4'b1000.
- Convert 0, then 65535 back-to-back (second start in the done cycle):
  - First result: bcd_out=16'h0000, blank=4'b1110 with macro.
  - Second done 17 cycles after the first: bcd_out=16'h5535, ovf=1, blank=4'b0000.
- Start while busy: start 9999, pulse start with bin_in=1234 at cycle 5 of CONV -> only one done, bcd_out=16'h9999; the second request is dropped.
- Reset mid-operation: start 4321, assert rst at cycle 8 of CONV -> no done, outputs zero. Then start 4321 again -> bcd_out=16'h4321 after 17 cycles.
- Counter sweep: apply 0..999 sequentially, each started on the previous done -> every bcd_out matches the decimal reference model, ovf never set.
